stream_fifo: RTL and testbench

STREAM_FIFO -- requirements
Module: stream_fifo

---
 rtl/stream_fifo_pkg.sv | 12 +
 rtl/stream_fifo_mem.sv | 26 ++
 rtl/stream_fifo.sv | 94 +++++++++
 tb/tb_stream_fifo.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared defaults and sizing helpers for the stream FIFO.
package stream_fifo_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 16;

  // Pointer width: address bits plus one wrap bit that tells full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module stream_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the incoming word into its slot.
  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Head word is read combinationally so it is visible as soon as it is stored.
  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready stream FIFO with first-word fall-through, flush and level flags.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] AF_THR = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_THR = CW'(AE_LVL);

  // Reject illegal parameterisations at elaboration.
  generate
    if ((DATA_W < 1) || (DATA_W > 512)) begin : g_bad_data_w
      $error("stream_fifo: DATA_W must be in 1..512");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("stream_fifo: DEPTH must be a power of two and at least 2");
    end
    if ((AF_LVL < 1) || (AF_LVL > DEPTH)) begin : g_bad_af
      $error("stream_fifo: AF_LVL must be in 1..DEPTH");
    end
    if ((AE_LVL < 0) || (AE_LVL > DEPTH - 1)) begin : g_bad_ae
      $error("stream_fifo: AE_LVL must be in 0..DEPTH-1");
    end
  endgenerate

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] ptr_diff;
  logic          push;
  logic          pop;

  // Status comes only from registered pointers, so no input feeds back to a ready/valid.
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty    = (wr_ptr == rd_ptr);
  assign s_ready  = !full;
  assign m_valid  = !empty;
  assign push     = s_valid && s_ready;
  assign pop      = m_valid && m_ready;

  // Occupancy is the modular pointer distance; it spans 0..DEPTH.
  assign ptr_diff     = wr_ptr - rd_ptr;
  assign count        = CW'(ptr_diff);
  assign almost_full  = (count >= AF_THR);
  assign almost_empty = (count <= AE_THR);

  // Pointer update: reset beats flush, flush discards any coincident push or pop.
  // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  stream_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (s_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (m_data)
  );

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo against a queue-based reference model.
module tb_stream_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          flush = 1'b0;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;

  logic [DW-1:0] model [$];
  int n_cmp = 0;
  int n_err = 0;

  stream_fifo #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .AF_LVL (AF),
    .AE_LVL (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .flush        (flush),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against what the queue model says the FIFO holds.
  task automatic check_outputs();
    int n;
    n = model.size();
    check("count",        64'(count),        64'(n));
    check("empty",        64'(empty),        64'(n == 0));
    check("full",         64'(full),         64'(n == DEPTH));
    check("s_ready",      64'(s_ready),      64'(n < DEPTH));
    check("m_valid",      64'(m_valid),      64'(n > 0));
    check("almost_full",  64'(almost_full),  64'(n >= AF));
    check("almost_empty", 64'(almost_empty), 64'(n <= AE));
    if (n > 0) check("m_data", 64'(m_data), 64'(model[0]));
  endtask

  // One clock: decide transfers from the model, advance, then check.
  task automatic cycle();
    bit do_push;
    bit do_pop;
    do_push = s_valid && (model.size() < DEPTH);
    do_pop  = m_ready && (model.size() > 0);
    @(posedge clk);
    #1;
    if (rst || flush) begin
      model.delete();
    end else begin
      if (do_pop)  void'(model.pop_front());
      if (do_push) model.push_back(s_data);
    end
    check_outputs();
  endtask

  initial begin
    logic [DW-1:0] lost_word;

    // Reset held two cycles, then idle outputs.
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    check("rst_s_ready", 64'(s_ready), 64'(1));
    check("rst_empty",   64'(empty),   64'(1));
    check("rst_count",   64'(count),   64'(0));
    check("rst_m_valid", 64'(m_valid), 64'(0));

    // No bypass: a word offered to an empty FIFO is not visible before the edge.
    s_valid = 1'b1;
    s_data  = 32'h0;
    m_ready = 1'b1;
    #1;
    check("nobypass_m_valid", 64'(m_valid), 64'(0));
    check("nobypass_count",   64'(count),   64'(0));
    m_ready = 1'b0;

    // Fill 0x00..0x0F; almost_full must first appear at count 14.
    for (int i = 0; i < DEPTH; i++) begin
      s_data = DW'(i);
      cycle();
      check("fill_af", 64'(almost_full), 64'((i + 1) >= 14));
    end
    check("fill_full",    64'(full),    64'(1));
    check("fill_s_ready", 64'(s_ready), 64'(0));

    // Push attempt while full is dropped.
    s_data = 32'hDEAD_BEEF;
    cycle();
    check("full_hold_count", 64'(count), 64'(DEPTH));
    s_valid = 1'b0;

    // Drain in order; almost_empty asserts once count reaches 2.
    m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_data", 64'(m_data), 64'(i));
      cycle();
      check("drain_ae", 64'(almost_empty), 64'((DEPTH - 1 - i) <= 2));
    end
    check("drain_empty", 64'(empty), 64'(1));

    // Build to half full, then stream 100 cycles with push and pop together.
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = $urandom;
      cycle();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_data = $urandom;
      cycle();
      check("stream_count", 64'(count), 64'(8));
    end

    // Fill to 16, then push+pop: only the pop lands, next cycle both land.
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_data = $urandom;
      cycle();
    end
    check("full16", 64'(count), 64'(16));
    m_ready = 1'b1;
    s_data  = 32'h1234_5678;
    cycle();
    check("full_pop_only", 64'(count), 64'(15));
    s_data = 32'h8765_4321;
    cycle();
    check("full_pop_push", 64'(count), 64'(15));

    // Drain to 5, flush with a coincident push and pop.
    s_valid = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    check("pre_flush", 64'(count), 64'(5));
    lost_word = 32'hF1F1_F1F1;
    s_valid = 1'b1;
    s_data  = lost_word;
    flush   = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_count", 64'(count), 64'(0));
    check("flush_empty", 64'(empty), 64'(1));
    m_ready = 1'b0;
    s_data  = 32'h0BAD_CAFE;
    cycle();
    check("post_flush_head", 64'(m_data), 64'(32'h0BAD_CAFE));
    check("post_flush_cnt",  64'(count),  64'(1));

    // Randomised traffic: push-heavy then pop-heavy, with rare flush and reset.
    for (int i = 0; i < 600; i++) begin
      if (i < 300) begin
        s_valid = ($urandom_range(0, 3) != 0);
        m_ready = ($urandom_range(0, 3) == 0);
      end else begin
        s_valid = ($urandom_range(0, 3) == 0);
        m_ready = ($urandom_range(0, 3) != 0);
      end
      s_data = $urandom;
      flush  = ($urandom_range(0, 47) == 0);
      rst    = ($urandom_range(0, 79) == 0);
      cycle();
    end
    rst     = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
